// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer:
// opcodes/functs, FSM states, datapath mux codes and instruction class flags.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_LUI  = 4'd4;

    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JUMP  = 2'd2;
    localparam logic [1:0] PC_RS    = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_R31   = 2'd2;

    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_MEM  = 2'd1;
    localparam logic [1:0] M2R_PC   = 2'd2;

    localparam logic [1:0] SEL_WORD = 2'd0;
    localparam logic [1:0] SEL_BYTE = 2'd1;
    localparam logic [1:0] SEL_HALF = 2'd2;

    typedef struct packed {
        logic rtype;
        logic ori;
        logic lui;
        logic load;
        logic store;
        logic beq;
        logic jal;
        logic jr;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_instr_class_decode.sv
// Combinational classification of the IR into one-hot class flags,
// plus the access width and ALU operation implied by the instruction.
module instr_class_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output iclass_t     cls_o,
    output logic [1:0]  sel_bit_o,
    output logic [3:0]  alu_op_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr;

    assign opcode       = instr_i[31:26];
    assign funct        = instr_i[5:0];
    assign unused_instr = ^instr_i[25:6];

    always_comb begin
        cls_o     = '0;
        sel_bit_o = SEL_WORD;
        alu_op_o  = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: cls_o.rtype = 1'b1;
                    FN_SUB, FN_SUBU: begin
                        cls_o.rtype = 1'b1;
                        alu_op_o    = ALU_SUB;
                    end
                    FN_JR:   cls_o.jr      = 1'b1;
                    default: cls_o.illegal = 1'b1;
                endcase
            end
            OP_ORI: begin
                cls_o.ori = 1'b1;
                alu_op_o  = ALU_OR;
            end
            OP_LUI: begin
                cls_o.lui = 1'b1;
                alu_op_o  = ALU_LUI;
            end
            OP_LW: cls_o.load = 1'b1;
            OP_LB: begin
                cls_o.load = 1'b1;
                sel_bit_o  = SEL_BYTE;
            end
            OP_LH: begin
                cls_o.load = 1'b1;
                sel_bit_o  = SEL_HALF;
            end
            OP_SW: cls_o.store = 1'b1;
            OP_SB: begin
                cls_o.store = 1'b1;
                sel_bit_o   = SEL_BYTE;
            end
            OP_SH: begin
                cls_o.store = 1'b1;
                sel_bit_o   = SEL_HALF;
            end
            OP_BEQ: begin
                cls_o.beq = 1'b1;
                alu_op_o  = ALU_SUB;
            end
            OP_JAL:  cls_o.jal     = 1'b1;
            default: cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the shared MIPS-subset
// datapath, with variable-latency memory handshakes and a retired counter.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src,
    output logic             ext_op,
    output logic [3:0]       alu_op,
    output logic [1:0]       sel_bit,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    iclass_t          cls;
    logic [1:0]       dec_sel;
    logic [3:0]       dec_alu;
    logic             ir_write_c, pc_write_c, reg_write_c, dmem_req_c, dmem_we_c;

    instr_class_decode u_dec (
        .instr_i   (instr),
        .cls_o     (cls),
        .sel_bit_o (dec_sel),
        .alu_op_o  (dec_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        retire      = 1'b0;
        imem_req    = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        pc_src      = PC_SEQ;
        reg_dst     = RD_RT;
        mem_to_reg  = M2R_ALU;
        alu_src     = 1'b0;
        ext_op      = 1'b0;
        alu_op      = ALU_ADD;
        sel_bit     = SEL_WORD;

        // IR is stale during FETCH; selects track the decoded class everywhere else.
        if (state_q != S_FETCH) begin
            pc_src     = cls.beq ? PC_BR : cls.jal ? PC_JUMP : cls.jr ? PC_RS : PC_SEQ;
            reg_dst    = cls.rtype ? RD_RD : cls.jal ? RD_R31 : RD_RT;
            mem_to_reg = cls.load ? M2R_MEM : cls.jal ? M2R_PC : M2R_ALU;
            alu_src    = cls.ori | cls.lui | cls.load | cls.store;
            ext_op     = cls.ori;
            alu_op     = dec_alu;
            sel_bit    = dec_sel;
        end

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (cls.jal) begin
                    reg_write_c = 1'b1;
                    pc_write_c  = 1'b1;
                    retire      = 1'b1;
                end else if (cls.jr) begin
                    pc_write_c = 1'b1;
                    retire     = 1'b1;
                end else if (!cls.illegal) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.beq) begin
                    pc_write_c = zero;
                    retire     = 1'b1;
                end else if (cls.load || cls.store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = cls.store;
                if (dmem_ready) begin
                    if (cls.store) retire = 1'b1;
                    else           state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
            end
            default: ;
        endcase
    end

    assign ir_write  = ir_write_c  & rst_n;
    assign pc_write  = pc_write_c  & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign dmem_req  = dmem_req_c  & rst_n;
    assign dmem_we   = dmem_we_c   & rst_n;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule
